// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// writeback (wb) and the long-latency unit (lu: late loads, mul/div).
//   - At most one grant per cycle. When both request, wb wins unless lu has
//     already lost STARVE_LIMIT consecutive cycles, in which case lu wins.
//   - The winning write is registered onto rf_we/rf_waddr/rf_wdata. Writes
//     to x0 are consumed (ready asserted) but never reach the port.
//   - busy[] is a scoreboard of registers awaiting a long-latency result.
//     It is set one edge after an issue and cleared one edge after the lu
//     grant for that register. Hazard logic must also compare against
//     rf_waddr while rf_we=1, because busy clears as the write lands.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous, active-low reset
//   wb_valid/rd/data  pipeline writeback request
//   wb_ready        wb granted this cycle (combinational)
//   lu_valid/rd/data  long-latency write request
//   lu_ready        lu granted this cycle (combinational)
//   lu_issue_valid/rd long-latency operation issued to rd
//   rf_we/waddr/wdata registered register-file write port
//   busy            registered scoreboard, bit i = reg i outstanding
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            wb_ready,
    input  logic            lu_valid,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    output logic            lu_ready,
    input  logic            lu_issue_valid,
    input  logic [4:0]      lu_issue_rd,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     busy
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]      starve_cnt_q, starve_cnt_d;
    logic            rf_we_q,      rf_we_d;
    logic [4:0]      rf_waddr_q,   rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q,   rf_wdata_d;
    logic [31:0]     busy_q,       busy_d;

    logic lu_priority;
    logic wb_grant;
    logic lu_grant;

    // -----------------------------------------------------------------------
    // Grant: depends only on the valids and the starvation counter, never on
    // rd/data. Both readies are held low while reset is asserted.
    // -----------------------------------------------------------------------
    always_comb begin
        lu_priority = (starve_cnt_q >= LIMIT);
        wb_grant    = 1'b0;
        lu_grant    = 1'b0;
        if (rst) begin
            if (wb_valid && lu_valid) begin
                lu_grant = lu_priority;
                wb_grant = !lu_priority;
            end else begin
                wb_grant = wb_valid;
                lu_grant = lu_valid;
            end
        end
    end

    assign wb_ready = wb_grant;
    assign lu_ready = lu_grant;

    // -----------------------------------------------------------------------
    // Starvation counter: counts cycles lu waits, saturating at the limit so
    // it never wraps past the priority threshold.
    // -----------------------------------------------------------------------
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (lu_grant) begin
            starve_cnt_d = 4'd0;
        end else if (lu_valid && (starve_cnt_q < LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Write port. A write to x0 is treated like no write at the port: the
    // enable drops and address/data keep their previous values.
    // -----------------------------------------------------------------------
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (wb_grant && (wb_rd != 5'd0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_rd;
            rf_wdata_d = wb_data;
        end else if (lu_grant && (lu_rd != 5'd0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = lu_rd;
            rf_wdata_d = lu_data;
        end
    end

    // -----------------------------------------------------------------------
    // Scoreboard, one bit per register. A same-cycle issue and completion to
    // the same register leaves the bit set: the new issue is still pending.
    // Bit 0 is tied low since x0 is never written.
    // -----------------------------------------------------------------------
    assign busy_d[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit   = lu_issue_valid && (lu_issue_rd == 5'(gi));
            assign clr_bit   = lu_grant && (lu_rd == 5'(gi));
            assign busy_d[gi] = set_bit | (busy_q[gi] & ~clr_bit);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= 4'd0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= 5'd0;
            rf_wdata_q   <= '0;
            busy_q       <= 32'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        lu_issue_valid;
    logic [4:0]  lu_issue_rd;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_ready       (wb_ready),
        .lu_valid       (lu_valid),
        .lu_rd          (lu_rd),
        .lu_data        (lu_data),
        .lu_ready       (lu_ready),
        .lu_issue_valid (lu_issue_valid),
        .lu_issue_rd    (lu_issue_rd),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .busy           (busy)
    );

    typedef struct {
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        iv;
        logic [4:0]  ird;
        logic        e_wr;
        logic        e_lr;
        logic        e_we;
        logic        chk_wr;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic [31:0] e_busy;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic iv, input logic [4:0] ird);
        wb_valid       = wv;
        wb_rd          = wrd;
        wb_data        = wd;
        lu_valid       = lv;
        lu_rd          = lrd;
        lu_data        = ld;
        lu_issue_valid = iv;
        lu_issue_rd    = ird;
    endtask

    initial begin
        // wv wrd wd            lv lrd ld         iv ird  wr lr we chk a   d             busy
        tbl[0]  = '{1, 5,  32'hDEADBEEF, 0, 0, 32'h0,        0, 0,  1, 0, 1, 1, 5,  32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1, 1,  32'h11110001, 0, 0, 32'h0,        0, 0,  1, 0, 1, 1, 1,  32'h11110001, 32'h0};
        tbl[2]  = '{1, 2,  32'h11110002, 0, 0, 32'h0,        0, 0,  1, 0, 1, 1, 2,  32'h11110002, 32'h0};
        tbl[3]  = '{1, 3,  32'h11110003, 0, 0, 32'h0,        0, 0,  1, 0, 1, 1, 3,  32'h11110003, 32'h0};
        tbl[4]  = '{0, 0,  32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 0, 1, 3,  32'h11110003, 32'h0};
        tbl[5]  = '{0, 0,  32'h0,        1, 0, 32'h55555555, 0, 0,  0, 1, 0, 0, 0,  32'h0,        32'h0};
        tbl[6]  = '{1, 0,  32'h66666666, 0, 0, 32'h0,        0, 0,  1, 0, 0, 0, 0,  32'h0,        32'h0};
        tbl[7]  = '{0, 0,  32'h0,        0, 0, 32'h0,        1, 7,  0, 0, 0, 0, 0,  32'h0,        32'h80};
        tbl[8]  = '{0, 0,  32'h0,        1, 7, 32'h00000077, 0, 0,  0, 1, 1, 1, 7,  32'h00000077, 32'h0};
        tbl[9]  = '{0, 0,  32'h0,        1, 7, 32'h00000078, 1, 7,  0, 1, 1, 1, 7,  32'h00000078, 32'h80};
        tbl[10] = '{0, 0,  32'h0,        1, 7, 32'h00000079, 0, 0,  0, 1, 1, 1, 7,  32'h00000079, 32'h0};
        tbl[11] = '{1, 31, 32'h000000FF, 0, 0, 32'h0,        1, 0,  1, 0, 1, 1, 31, 32'h000000FF, 32'h0};

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset_busy", busy, 32'd0);
        rst = 1'b1;

        // Get a write in flight and a scoreboard bit set, then reset mid-cycle.
        drive(1, 4, 32'hA5A5A5A5, 0, 0, 0, 1, 12);
        @(posedge clk);
        #1;
        chk("pre_reset_rf_we", {31'd0, rf_we}, 32'd1);
        chk("pre_reset_busy", busy, 32'h00001000);
        drive(1, 4, 32'hA5A5A5A5, 1, 9, 32'h9, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_rf_we", {31'd0, rf_we}, 32'd0);
        chk("async_reset_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("async_reset_wdata", rf_wdata, 32'd0);
        chk("async_reset_busy", busy, 32'd0);
        chk("reset_wb_ready", {31'd0, wb_ready}, 32'd0);
        chk("reset_lu_ready", {31'd0, lu_ready}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("held_reset_rf_we", {31'd0, rf_we}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].wv, tbl[i].wrd, tbl[i].wd, tbl[i].lv, tbl[i].lrd, tbl[i].ld,
                  tbl[i].iv, tbl[i].ird);
            #1;
            chk($sformatf("v%0d_wb_ready", i), {31'd0, wb_ready}, {31'd0, tbl[i].e_wr});
            chk($sformatf("v%0d_lu_ready", i), {31'd0, lu_ready}, {31'd0, tbl[i].e_lr});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rf_we", i), {31'd0, rf_we}, {31'd0, tbl[i].e_we});
            if (tbl[i].chk_wr) begin
                chk($sformatf("v%0d_rf_waddr", i), {27'd0, rf_waddr}, {27'd0, tbl[i].e_a});
                chk($sformatf("v%0d_rf_wdata", i), rf_wdata, tbl[i].e_d);
            end
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            $display("vec %0d: wb_ready=%0b lu_ready=%0b rf_we=%0b waddr=%0d wdata=0x%08h busy=0x%08h",
                     i, wb_ready, lu_ready, rf_we, rf_waddr, rf_wdata, busy);
        end

        // Contention: both held high; wb wins 4 cycles, lu on the 5th, wb again on the 6th.
        for (int c = 0; c < 6; c++) begin
            logic exp_lu;
            exp_lu = (c == 4);
            drive(1, 9, 32'h90000000 + 32'(c), 1, 10, 32'hA0000000, 0, 0);
            #1;
            chk($sformatf("cont%0d_wb_ready", c), {31'd0, wb_ready}, {31'd0, !exp_lu});
            chk($sformatf("cont%0d_lu_ready", c), {31'd0, lu_ready}, {31'd0, exp_lu});
            @(posedge clk);
            #1;
            chk($sformatf("cont%0d_rf_we", c), {31'd0, rf_we}, 32'd1);
            chk($sformatf("cont%0d_rf_waddr", c), {27'd0, rf_waddr}, exp_lu ? 32'd10 : 32'd9);
            $display("contention cycle %0d: rf_waddr=%0d rf_wdata=0x%08h", c, rf_waddr, rf_wdata);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("idle_rf_we", {31'd0, rf_we}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port between the in-order pipeline writeback and the long-latency unit (loads completing late, multicycle mul/div). Arbitrates between the two requesters with a starvation guard, registers the winning write onto the port, and drops writes to x0. Also keeps a per-register scoreboard of outstanding long-latency destinations for the hazard logic. Sits between the writeback stage / long-latency unit and the register file.

## Interface
- `XLEN`, 32, data width of a register write
- `STARVE_LIMIT`, 4, consecutive lost cycles after which the long-latency requester wins; legal range 1..15
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `wb_valid`  in  1  pipeline writeback request
- `wb_rd`  in  5  pipeline destination register
- `wb_data`  in  XLEN  pipeline write data
- `wb_ready`  out  1  pipeline request granted this cycle (combinational)
- `lu_valid`  in  1  long-latency unit write request
- `lu_rd`  in  5  long-latency destination register
- `lu_data`  in  XLEN  long-latency write data
- `lu_ready`  out  1  long-latency request granted this cycle (combinational)
- `lu_issue_valid`  in  1  a long-latency operation was issued
- `lu_issue_rd`  in  5  destination of the issued operation
- `rf_we`  out  1  register-file write enable (registered)
- `rf_waddr`  out  5  register-file write address (registered)
- `rf_wdata`  out  XLEN  register-file write data (registered)
- `busy`  out  32  scoreboard, bit i = register i awaiting long-latency result (registered)

## Operation
- Handshake per requester: transfer when valid && ready at a rising edge. A requester holds valid, rd, and data stable until ready. The arbiter never deasserts ready on a pending valid except in favour of the other requester.
- Grant, at most one per cycle:
  - Only one valid: that requester is granted.
  - Both valid: grant lu if `starve_cnt >= STARVE_LIMIT`, else grant wb.
  - Neither valid: no grant.
- `starve_cnt` (width 4):
  - Increments, saturating at STARVE_LIMIT, each cycle lu_valid && !lu_ready.
  - Clears to 0 on an lu grant.
  - Holds when lu_valid is low.
- Write port, on a granted transfer: next edge loads rf_we=1, rf_waddr=rd, rf_wdata=data.
  - rd==0: the transfer is still consumed (ready asserted) but rf_we=0 next cycle.
  - No grant: rf_we=0 next cycle; rf_waddr/rf_wdata hold their last values.
- Scoreboard:
  - lu_issue_valid with lu_issue_rd!=0 sets busy[lu_issue_rd] on the next edge.
  - An lu grant clears busy[lu_rd].
  - Set and clear of the same bit in one cycle: set wins (new issue outstanding).
  - busy[0] is always 0.
- Reset (rst=0, any time, asynchronous): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, starve_cnt=0. A transfer in flight is discarded. wb_ready/lu_ready follow the combinational rule and are forced to 0 while rst=0.

## Timing
- wb_ready/lu_ready: same-cycle combinational from wb_valid, lu_valid, and starve_cnt; no path from data inputs.
- Latency: accepted at edge N → rf_we/rf_waddr/rf_wdata valid during cycle N+1; register file writes at edge N+1.
- Throughput: one write per cycle; back-to-back grants produce a continuous rf_we.
- busy updates one edge after issue/grant. Hazard logic must also compare against rf_waddr while rf_we=1.
- Worst-case lu wait with wb saturating: STARVE_LIMIT cycles, granted in cycle STARVE_LIMIT+1.

## Test plan
- Reset: drive rst=0 mid-write with rf_we=1 → rf_we=0, busy=0 immediately (asynchronous); after release, first wb_valid with rd=5, data=0xDEADBEEF → wb_ready=1, next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- Contention: wb_valid and lu_valid both held high, STARVE_LIMIT=4 → wb granted 4 cycles, lu granted on the 5th, starve_cnt back to 0, wb regranted on the 6th.
- x0 discard: lu_valid with lu_rd=0 → lu_ready=1, rf_we=0 next cycle; wb_rd=0 behaves the same.
- Scoreboard: issue rd=7 → busy[7]=1 next cycle; lu grant rd=7 → busy[7]=0 next cycle; issue rd=7 and lu grant rd=7 in the same cycle → busy[7] stays 1.
- Back-to-back: wb writes rd=1,2,3 on consecutive cycles with no lu traffic → rf_we high 3 consecutive cycles, addresses 1,2,3 in order, no bubble.
